// File: rtl/dca_lsu_rdata_aligner_if.sv
// Read-beat in / aligned-word out handshake bundle for dca_lsu_rdata_aligner.
// master: beat producer + row-buffer consumer side; slave: the aligner.
`timescale 1ns/1ps
interface dca_lsu_rdata_aligner_if #(
    parameter int unsigned BW_ROW         = 256,
    parameter int unsigned BW_OFFSET      = 8,
    parameter int unsigned MATRIX_NUM_COL = 16,
    parameter int unsigned BW_INFO        = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BW_ROW-1:0]         in_data;
    logic                      in_first;
    logic                      in_last;
    logic [BW_OFFSET-1:0]      in_offset;
    logic [MATRIX_NUM_COL-1:0] in_colmask;
    logic [2:0]                in_elem_code;
    logic [BW_INFO-1:0]        in_info;

    logic                      out_valid;
    logic                      out_ready;
    logic [BW_ROW-1:0]         out_data;
    logic [BW_ROW-1:0]         out_mask;
    logic                      out_last;
    logic [BW_INFO-1:0]        out_info;

    modport master (
        output in_valid, in_data, in_first, in_last, in_offset, in_colmask,
               in_elem_code, in_info, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_last, out_info
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, in_offset, in_colmask,
               in_elem_code, in_info, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_last, out_info
    );
endinterface

// File: rtl/dca_lsu_rdata_aligner.sv
// Streaming funnel-shift aligner: turns offset AXI read beats into bit-0-aligned row words.
// DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN enables bit-granular offsets and element codes below 3.
`timescale 1ns/1ps
module dca_lsu_rdata_aligner #(
    parameter int unsigned BW_ROW         = 256,
    parameter int unsigned BW_OFFSET      = 8,
    parameter int unsigned MATRIX_NUM_COL = 16,
    parameter int unsigned BW_INFO        = 16
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          clear,
    dca_lsu_rdata_aligner_if.slave        bus,
    output logic                          busy
);

    localparam int unsigned FW = 2 * BW_ROW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]                state_q,     state_d;
    logic [BW_ROW-1:0]         residual_q,  residual_d;
    logic [BW_OFFSET-1:0]      offset_q,    offset_d;
    logic [MATRIX_NUM_COL-1:0] colmask_q,   colmask_d;
    logic [2:0]                code_q,      code_d;
    logic [BW_INFO-1:0]        info_q,      info_d;
    logic                      out_valid_q, out_valid_d;
    logic [BW_ROW-1:0]         out_data_q,  out_data_d;
    logic [BW_ROW-1:0]         out_mask_q,  out_mask_d;
    logic                      out_last_q,  out_last_d;
    logic [BW_INFO-1:0]        out_info_q,  out_info_d;
    logic                      busy_q,      busy_d;

    logic                      idle, absorb, out_free, in_ready_c, fire, load_out;
    logic [BW_OFFSET-1:0]      in_off_eff, off;
    logic [2:0]                in_code_eff;
    logic [BW_ROW-1:0]         hi, lo, aligned, mask_c;
    logic [FW-1:0]             funnel;
    logic                      unused_bits;

    // Replicate each column bit over its 2^code-bit element; columns past the row drop off.
    function automatic logic [BW_ROW-1:0] expand_mask(input logic [MATRIX_NUM_COL-1:0] cm,
                                                      input logic [2:0] code);
        logic [BW_ROW-1:0] elem;
        logic [BW_ROW-1:0] m;
        int unsigned       esz;
        esz  = 32'd1 << code;
        elem = (BW_ROW'(1) << esz) - BW_ROW'(1);
        m    = '0;
        for (int unsigned c = 0; c < MATRIX_NUM_COL; c++) begin
            if (cm[c]) m = m | (elem << (c * esz));
        end
        return m;
    endfunction

`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
    assign in_off_eff  = bus.in_offset;
    assign in_code_eff = bus.in_elem_code;
`else
    assign in_off_eff  = {bus.in_offset[BW_OFFSET-1:3], 3'b000};
    assign in_code_eff = (bus.in_elem_code < 3'd3) ? 3'd3 : bus.in_elem_code;
`endif

    assign idle     = (state_q == S_IDLE);
    assign out_free = ~out_valid_q | bus.out_ready;
    // An unaligned non-last first beat only fills the residual, so it needs no output slot.
    assign absorb     = bus.in_first & (in_off_eff != '0) & ~bus.in_last;
    assign in_ready_c = idle ? (absorb | ~bus.in_first | out_free) : out_free;
    assign fire       = bus.in_valid & in_ready_c;

    assign off = idle ? in_off_eff : offset_q;
    assign hi  = idle ? '0 : bus.in_data;
    assign lo  = (idle || off == '0) ? bus.in_data : residual_q;

`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
    assign funnel      = {hi, lo} >> off;
    assign unused_bits = ^funnel[FW-1:BW_ROW];
`else
    // Byte-step barrel: one mux stage per offset bit from bit 3 upward.
    logic [FW-1:0] stage [0:BW_OFFSET-3];
    assign stage[0] = {hi, lo};
    for (genvar g = 3; g < BW_OFFSET; g++) begin : g_byte_shift
        assign stage[g-2] = off[g] ? (stage[g-3] >> (1 << g)) : stage[g-3];
    end
    assign funnel      = stage[BW_OFFSET-3];
    assign unused_bits = ^{funnel[FW-1:BW_ROW], off[2:0], bus.in_offset[2:0]};
`endif

    assign aligned = funnel[BW_ROW-1:0];
    assign mask_c  = expand_mask(idle ? bus.in_colmask : colmask_q,
                                 idle ? in_code_eff    : code_q);

    // Next-state and datapath-load decode.
    always_comb begin
        state_d     = state_q;
        residual_d  = residual_q;
        offset_d    = offset_q;
        colmask_d   = colmask_q;
        code_d      = code_q;
        info_d      = info_q;
        load_out    = 1'b0;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        out_info_d  = out_info_q;

        if (fire) begin
            if (idle) begin
                if (bus.in_first) begin
                    offset_d  = in_off_eff;
                    colmask_d = bus.in_colmask;
                    code_d    = in_code_eff;
                    info_d    = bus.in_info;
                    if (absorb) begin
                        residual_d = bus.in_data;
                        state_d    = S_PRIME;
                    end else begin
                        load_out = 1'b1;
                        state_d  = bus.in_last ? S_IDLE : S_STREAM;
                    end
                end
            end else begin
                load_out   = 1'b1;
                residual_d = bus.in_data;
                state_d    = bus.in_last ? S_IDLE : S_STREAM;
            end
        end

        if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = aligned;
            out_mask_d  = mask_c;
            out_last_d  = bus.in_last;
            out_info_d  = idle ? bus.in_info : info_q;
        end

        busy_d = (state_d != S_IDLE) | out_valid_d;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= S_IDLE;
            residual_q  <= '0;
            offset_q    <= '0;
            colmask_q   <= '0;
            code_q      <= '0;
            info_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
            out_info_q  <= '0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            residual_q  <= '0;
            offset_q    <= '0;
            colmask_q   <= '0;
            code_q      <= '0;
            info_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
            out_info_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            residual_q  <= residual_d;
            offset_q    <= offset_d;
            colmask_q   <= colmask_d;
            code_q      <= code_d;
            info_q      <= info_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
            out_info_q  <= out_info_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_info  = out_info_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dca_lsu_rdata_aligner.sv
// Scoreboard bench for dca_lsu_rdata_aligner: directed cases plus random transactions vs a bit-stream model.
`timescale 1ns/1ps
module tb_dca_lsu_rdata_aligner;

    localparam int unsigned W  = 32;
    localparam int unsigned OW = 5;
    localparam int unsigned NC = 4;
    localparam int unsigned IW = 16;
    localparam int unsigned SW = W * 8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [W-1:0]  mask;
        logic          last;
        logic [IW-1:0] info;
    } exp_t;

    logic clk = 1'b0;
    logic rstnn;
    logic clear;
    logic busy;
    int   rmode;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    dca_lsu_rdata_aligner_if #(.BW_ROW(W), .BW_OFFSET(OW), .MATRIX_NUM_COL(NC), .BW_INFO(IW)) bus();

    dca_lsu_rdata_aligner #(.BW_ROW(W), .BW_OFFSET(OW), .MATRIX_NUM_COL(NC), .BW_INFO(IW)) dut (
        .clk   (clk),
        .rstnn (rstnn),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic summary_and_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_off(input int o);
`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
        return o;
`else
        return o & ~7;
`endif
    endfunction

    function automatic int eff_code(input int c);
`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
        return c;
`else
        return (c < 3) ? 3 : c;
`endif
    endfunction

    function automatic logic [W-1:0] ref_mask(input logic [NC-1:0] cm, input int code);
        logic [W-1:0]  m;
        logic [NC-1:0] t;
        int            esz;
        int            col;
        esz = 1 << eff_code(code);
        m   = '0;
        for (int b = 0; b < W; b++) begin
            col = b / esz;
            if (col < NC) begin
                t = cm >> col;
                if (t[0]) m = m | (W'(1) << b);
            end
        end
        return m;
    endfunction

    // Concatenate beats into one LSB-first bit stream and read words starting at the offset.
    task automatic model_push(input logic [W-1:0] beats[$], input int off, input logic [NC-1:0] cm,
                              input int code, input logic [IW-1:0] info);
        logic [SW-1:0] stream;
        exp_t          e;
        int            o, n, cnt;
        stream = '0;
        n      = beats.size();
        for (int i = 0; i < n; i++) stream = stream | (SW'(beats[i]) << (W * i));
        o   = eff_off(off);
        cnt = (o == 0 || n == 1) ? n : n - 1;
        for (int i = 0; i < cnt; i++) begin
            e.data = W'(stream >> (o + W * i));
            e.mask = ref_mask(cm, code);
            e.last = (i == cnt - 1);
            e.info = info;
            sb.push_back(e);
        end
    endtask

    task automatic push_lit(input logic [W-1:0] d, input logic [W-1:0] m, input logic l,
                            input logic [IW-1:0] i);
        exp_t e;
        e.data = d; e.mask = m; e.last = l; e.info = i;
        sb.push_back(e);
    endtask

    // ---------------- drivers ----------------
    task automatic set_beat(input logic [W-1:0] d, input logic first, input logic last,
                            input int off, input logic [NC-1:0] cm, input int code,
                            input logic [IW-1:0] info);
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.in_first     = first;
        bus.in_last      = last;
        bus.in_offset    = OW'(off);
        bus.in_colmask   = cm;
        bus.in_elem_code = 3'(code);
        bus.in_info      = info;
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k > 300) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                summary_and_stop();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic first, input logic last,
                        input int off, input logic [NC-1:0] cm, input int code,
                        input logic [IW-1:0] info);
        set_beat(d, first, last, off, cm, code, info);
        wait_accept();
        bus.in_valid = 1'b0;
    endtask

    // Later beats carry junk sideband and stray in_first, which must be ignored.
    task automatic drive_txn(input logic [W-1:0] beats[$], input int off, input logic [NC-1:0] cm,
                             input int code, input logic [IW-1:0] info, input bit gaps);
        int n;
        n = beats.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            if (i == 0)
                set_beat(beats[i], 1'b1, n == 1, off, cm, code, info);
            else
                set_beat(beats[i], $urandom_range(0, 7) == 0, i == n - 1, $urandom_range(0, 31),
                         NC'($urandom), $urandom_range(0, 5), IW'($urandom));
            wait_accept();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- downstream ready ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t          e;
        bit            hold_pend;
        logic [W-1:0]  hd, hm;
        logic          hl;
        logic [IW-1:0] hi;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstnn || clear) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("hold_data",  64'(bus.out_data), 64'(hd));
                    chk("hold_mask",  64'(bus.out_mask), 64'(hm));
                    chk("hold_last",  64'(bus.out_last), 64'(hl));
                    chk("hold_info",  64'(bus.out_info), 64'(hi));
                end
                hold_pend = bus.out_valid && !bus.out_ready;
                hd = bus.out_data; hm = bus.out_mask; hl = bus.out_last; hi = bus.out_info;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", 64'(bus.out_data), 64'd0);
                        if (bus.out_data == '0) begin
                            bad++;
                            $display("FAIL unexpected_word: got word with empty scoreboard");
                        end
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'(bus.out_data), 64'(e.data));
                        chk("out_mask", 64'(bus.out_mask), 64'(e.mask));
                        chk("out_last", 64'(bus.out_last), 64'(e.last));
                        chk("out_info", 64'(bus.out_info), 64'(e.info));
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        chk("global_timeout", 64'd0, 64'd1);
        summary_and_stop();
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] q[$];
        int           n, off, code;
        logic [NC-1:0] cm;
        logic [IW-1:0] info;

        rstnn = 1'b0; clear = 1'b0; rmode = 0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_offset = '0; bus.in_colmask = '0; bus.in_elem_code = '0; bus.in_info = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_mask",  64'(bus.out_mask),  64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_out_info",  64'(bus.out_info),  64'd0);
        @(posedge clk); #1;
        rstnn = 1'b1;
        @(posedge clk); #1;

        // Aligned single beat, one-cycle latency.
        push_lit(32'hA1B2C3D4, 32'hFFFFFFFF, 1'b1, 16'h1111);
        send(32'hA1B2C3D4, 1'b1, 1'b1, 0, 4'hF, 3, 16'h1111);
        chk("lat1_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // Unaligned 3-beat with 3 cycles of downstream stall on the first output.
        push_lit(32'h55443322, 32'hFFFFFFFF, 1'b0, 16'h2222);
        push_lit(32'h99887766, 32'hFFFFFFFF, 1'b1, 16'h2222);
        send(32'h44332211, 1'b1, 1'b0, 8, 4'hF, 3, 16'h2222);
        chk("no_out_first_beat", 64'(bus.out_valid), 64'd0);
        send(32'h88776655, 1'b0, 1'b0, 8'd0, 4'h0, 0, 16'h0);
        rmode = 2; bus.out_ready = 1'b0;
        set_beat(32'hCCBBAA99, 1'b0, 1'b1, 0, 4'h0, 0, 16'h0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_data", 64'(bus.out_data), 64'h55443322);
        end
        @(posedge clk); #1;
        rmode = 0; bus.out_ready = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        drain();

        // Single unaligned beat, offset 12.
`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
        push_lit(32'h000FFFF0, 32'hFFFFFFFF, 1'b1, 16'h3333);
`else
        push_lit(32'h00FFFF00, 32'hFFFFFFFF, 1'b1, 16'h3333);
`endif
        send(32'hFFFF0000, 1'b1, 1'b1, 12, 4'hF, 3, 16'h3333);
        drain();

        // Mask expansion with colmask 0101, code 2.
`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
        push_lit(32'h12345678, 32'h00000F0F, 1'b1, 16'h4444);
`else
        push_lit(32'h12345678, 32'h00FF00FF, 1'b1, 16'h4444);
`endif
        send(32'h12345678, 1'b1, 1'b1, 0, 4'b0101, 2, 16'h4444);
        drain();

        // Nibble offset on a single beat.
`ifdef DCA_LSU_RDATA_ALIGNER_SUBBYTE_EN
        push_lit(32'h08765432, 32'hFFFFFFFF, 1'b1, 16'h5555);
`else
        push_lit(32'h87654321, 32'hFFFFFFFF, 1'b1, 16'h5555);
`endif
        send(32'h87654321, 1'b1, 1'b1, 4, 4'hF, 3, 16'h5555);
        drain();

        // Clear while in PRIME, then an aligned transaction.
        send(32'hCAFEF00D, 1'b1, 1'b0, 8, 4'hF, 3, 16'h6666);
        chk("prime_busy", 64'(busy), 64'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_busy",      64'(busy),          64'd0);
        chk("clear_out_valid", 64'(bus.out_valid), 64'd0);
        push_lit(32'hDEADBEEF, 32'hFFFF0000, 1'b1, 16'h7777);
        send(32'hDEADBEEF, 1'b1, 1'b1, 0, 4'b0010, 4, 16'h7777);
        drain();

        // Async reset while in PRIME.
        send(32'h0BADBEEF, 1'b1, 1'b0, 16, 4'hF, 3, 16'h8888);
        rstnn = 1'b0;
        #2;
        chk("arst_busy",      64'(busy),          64'd0);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        rstnn = 1'b1;
        @(posedge clk); #1;
        push_lit(32'h13572468, 32'hFFFFFFFF, 1'b1, 16'h9999);
        send(32'h13572468, 1'b1, 1'b1, 0, 4'hF, 5, 16'h9999);
        drain();

        // Random transactions under random backpressure.
        rmode = 1;
        for (int t = 0; t < 60; t++) begin
            q.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) q.push_back(W'($urandom));
            off  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
            cm   = NC'($urandom);
            code = $urandom_range(0, 5);
            info = IW'($urandom);
            model_push(q, off, cm, code, info);
            drive_txn(q, off, cm, code, info, 1'b1);
        end
        drain();
        rmode = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("end_out_valid", 64'(bus.out_valid), 64'd0);
        chk("end_busy",      64'(busy),          64'd0);
        summary_and_stop();
    end

endmodule
